// File: rtl/reg_file_wb.sv
// ============================================================================
//  Module      : reg_file_wb
//  Description : RV32 integer register file with write-first bypass and a
//                per-register pending-write scoreboard for the hazard unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_wb #(
   parameter int XLEN    = 32,
   parameter int SB_BITS = 2
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            WB_WRITE_ENABLE,
   input  logic [XLEN-1:0] WB_WRITE_DATA,
   input  logic [4:0]      WB_RD,
   input  logic [4:0]      ID_RS1,
   input  logic [4:0]      ID_RS2,
   output logic [XLEN-1:0] ID_READ_DATA1,
   output logic [XLEN-1:0] ID_READ_DATA2,
   input  logic            ID_ISSUE_VALID,
   input  logic            ID_ISSUE_WRITE_ENABLE,
   input  logic [4:0]      ID_ISSUE_RD,
   input  logic            SQUASH_VALID,
   input  logic [4:0]      SQUASH_RD,
   output logic            ID_RS1_PENDING,
   output logic            ID_RS2_PENDING,
   output logic            SB_ERROR
);

   localparam int SB_MAX = (1 << SB_BITS) - 1;

   logic [XLEN-1:0] rf_w [0:31];
   logic [31:0]     pend_w;
   logic [31:1]     err_vec_w;
   logic            sb_error_q;

   // Entry 0 is the hardwired zero register: no storage, no counter.
   assign rf_w[0]   = '0;
   assign pend_w[0] = 1'b0;

   generate
      for (genvar r = 1; r < 32; r++) begin : g_regs
         logic [XLEN-1:0]    reg_q;
         logic [SB_BITS-1:0] cnt_q;
         logic [SB_BITS-1:0] cnt_d;
         logic               inc_w;
         logic               dec_wb_w;
         logic               dec_sq_w;
         logic               err_w;
         int                 sum_w;

         assign inc_w    = ID_ISSUE_VALID && ID_ISSUE_WRITE_ENABLE && (ID_ISSUE_RD == 5'(r));
         assign dec_wb_w = WB_WRITE_ENABLE && (WB_RD == 5'(r));
         assign dec_sq_w = SQUASH_VALID && (SQUASH_RD == 5'(r));

         // Net change may range from -2 to +1; clamp and flag out-of-range results.
         always_comb begin
            sum_w = int'(cnt_q) + int'(inc_w) - int'(dec_wb_w) - int'(dec_sq_w);
            err_w = 1'b0;
            cnt_d = cnt_q;
            if (sum_w > SB_MAX) begin
               cnt_d = SB_BITS'(SB_MAX);
               err_w = 1'b1;
            end else if (sum_w < 0) begin
               cnt_d = '0;
               err_w = 1'b1;
            end else begin
               cnt_d = SB_BITS'(sum_w);
            end
         end

         always_ff @(posedge CLK) begin
            if (RST) begin
               reg_q <= '0;
               cnt_q <= '0;
            end else begin
               if (dec_wb_w) begin
                  reg_q <= WB_WRITE_DATA;
               end
               cnt_q <= cnt_d;
            end
         end

         assign rf_w[r]      = reg_q;
         assign pend_w[r]    = |cnt_q;
         assign err_vec_w[r] = err_w;
      end
   endgenerate

   always_ff @(posedge CLK) begin
      if (RST) begin
         sb_error_q <= 1'b0;
      end else begin
         sb_error_q <= sb_error_q | (|err_vec_w);
      end
   end

   always_comb begin
      ID_READ_DATA1 = rf_w[ID_RS1];
      if (ID_RS1 == 5'd0) begin
         ID_READ_DATA1 = '0;
      end else if (WB_WRITE_ENABLE && (WB_RD == ID_RS1)) begin
         ID_READ_DATA1 = WB_WRITE_DATA;
      end
   end

   always_comb begin
      ID_READ_DATA2 = rf_w[ID_RS2];
      if (ID_RS2 == 5'd0) begin
         ID_READ_DATA2 = '0;
      end else if (WB_WRITE_ENABLE && (WB_RD == ID_RS2)) begin
         ID_READ_DATA2 = WB_WRITE_DATA;
      end
   end

   // Pending reflects the pre-edge count; same-cycle retires are forwarded elsewhere.
   assign ID_RS1_PENDING = pend_w[ID_RS1];
   assign ID_RS2_PENDING = pend_w[ID_RS2];
   assign SB_ERROR       = sb_error_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_wb.sv
// ============================================================================
//  Module      : tb_reg_file_wb
//  Description : Self-checking bench for reg_file_wb against an array model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file_wb;

   localparam int XLEN   = 32;
   localparam int SB_BITS = 2;
   localparam int CNT_MAX = (1 << SB_BITS) - 1;

   logic            CLK = 1'b0;
   logic            RST;
   logic            we;
   logic [XLEN-1:0] wdata;
   logic [4:0]      wrd;
   logic [4:0]      rs1, rs2;
   logic [XLEN-1:0] rd1, rd2;
   logic            iv, iwe;
   logic [4:0]      ird;
   logic            sqv;
   logic [4:0]      sqrd;
   logic            p1, p2, sberr;

   int errors = 0;
   int checks = 0;

   logic [XLEN-1:0] m_reg [32];
   int              m_cnt [32];
   bit              m_err;

   always #5 CLK = ~CLK;

   reg_file_wb #(.XLEN(XLEN), .SB_BITS(SB_BITS)) dut (
      .CLK                   (CLK),
      .RST                   (RST),
      .WB_WRITE_ENABLE       (we),
      .WB_WRITE_DATA         (wdata),
      .WB_RD                 (wrd),
      .ID_RS1                (rs1),
      .ID_RS2                (rs2),
      .ID_READ_DATA1         (rd1),
      .ID_READ_DATA2         (rd2),
      .ID_ISSUE_VALID        (iv),
      .ID_ISSUE_WRITE_ENABLE (iwe),
      .ID_ISSUE_RD           (ird),
      .SQUASH_VALID          (sqv),
      .SQUASH_RD             (sqrd),
      .ID_RS1_PENDING        (p1),
      .ID_RS2_PENDING        (p2),
      .SB_ERROR              (sberr)
   );

   // Architectural model: what one clock edge does to registers and counts.
   task automatic model_edge();
      if (RST) begin
         for (int r = 0; r < 32; r++) begin
            m_reg[r] = '0;
            m_cnt[r] = 0;
         end
         m_err = 1'b0;
      end else begin
         if (we && wrd != 0) m_reg[wrd] = wdata;
         for (int r = 1; r < 32; r++) begin
            int n;
            n = m_cnt[r];
            if (iv && iwe && ird == r) n = n + 1;
            if (we && wrd == r) n = n - 1;
            if (sqv && sqrd == r) n = n - 1;
            if (n > CNT_MAX) begin n = CNT_MAX; m_err = 1'b1; end
            if (n < 0) begin n = 0; m_err = 1'b1; end
            m_cnt[r] = n;
         end
      end
   endtask

   function automatic logic [XLEN-1:0] m_read(input logic [4:0] rs);
      if (rs == 0) return '0;
      if (we && wrd == rs) return wdata;
      return m_reg[rs];
   endfunction

   task automatic idle();
      RST = 1'b0; we = 1'b0; wdata = '0; wrd = '0; rs1 = '0; rs2 = '0;
      iv = 1'b0; iwe = 1'b0; ird = '0; sqv = 1'b0; sqrd = '0;
   endtask

   task automatic step();
      @(posedge CLK);
      model_edge();
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic do_reset();
      idle();
      RST = 1'b1;
      step();
      RST = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      RST = 1'b1; we = 1'b1; wrd = 5'd5; wdata = 32'h1111_2222;
      iv = 1'b1; iwe = 1'b1; ird = 5'd5; sqv = 1'b1; sqrd = 5'd6;
      step();
      idle();
      rs1 = 5'd5; rs2 = 5'd0;
      settle();
      checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL reset_rd1 got=%h exp=%h", rd1, 32'h0); end
      checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL reset_rd2 got=%h exp=%h", rd2, 32'h0); end
      checks++; if (p1 !== 1'b0 || p2 !== 1'b0) begin errors++; $display("FAIL reset_pending got=%b%b exp=00", p1, p2); end
      checks++; if (sberr !== 1'b0) begin errors++; $display("FAIL reset_sberr got=%b exp=0", sberr); end
   endtask

   task automatic test_write_bypass();
      idle();
      we = 1'b1; wrd = 5'd1; wdata = 32'hDEAD_BEEF; rs1 = 5'd1;
      settle();
      checks++; if (rd1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_same got=%h exp=deadbeef", rd1); end
      step();
      idle(); rs1 = 5'd1; rs2 = 5'd1;
      settle();
      checks++; if (rd1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL array_next got=%h exp=deadbeef", rd1); end
      checks++; if (rd2 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL array_next2 got=%h exp=deadbeef", rd2); end
      // Retiring x1 with no issue behind it is an underflow.
      checks++; if (sberr !== 1'b1) begin errors++; $display("FAIL underflow_x1 got=%b exp=1", sberr); end
      we = 1'b1; wrd = 5'd0; wdata = 32'hCAFE_BABE; rs1 = 5'd0; rs2 = 5'd0;
      settle();
      checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL x0_bypass got=%h exp=0", rd1); end
      step();
      idle();
      settle();
      checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL x0_read got=%h exp=0", rd2); end
   endtask

   task automatic test_scoreboard();
      do_reset();
      idle(); iv = 1'b1; iwe = 1'b1; ird = 5'd7;
      step();
      step();
      idle(); rs2 = 5'd7;
      settle();
      checks++; if (p2 !== 1'b1) begin errors++; $display("FAIL sb_pending2 got=%b exp=1", p2); end
      we = 1'b1; wrd = 5'd7; wdata = 32'h0000_0007;
      step();
      idle(); rs2 = 5'd7;
      settle();
      checks++; if (p2 !== 1'b1) begin errors++; $display("FAIL sb_after_one got=%b exp=1", p2); end
      we = 1'b1; wrd = 5'd7; wdata = 32'h0000_0077;
      settle();
      checks++; if (p2 !== 1'b1) begin errors++; $display("FAIL sb_no_retire_bypass got=%b exp=1", p2); end
      step();
      idle(); rs2 = 5'd7;
      settle();
      checks++; if (p2 !== 1'b0) begin errors++; $display("FAIL sb_after_two got=%b exp=0", p2); end
      checks++; if (sberr !== 1'b0) begin errors++; $display("FAIL sb_err got=%b exp=0", sberr); end
      // Issue with write-enable low must not count.
      iv = 1'b1; iwe = 1'b0; ird = 5'd7;
      step();
      idle(); rs2 = 5'd7;
      settle();
      checks++; if (p2 !== 1'b0) begin errors++; $display("FAIL sb_nowe_issue got=%b exp=0", p2); end
   endtask

   task automatic test_simultaneous();
      idle(); iv = 1'b1; iwe = 1'b1; ird = 5'd3;
      step();
      iv = 1'b1; iwe = 1'b1; ird = 5'd3; we = 1'b1; wrd = 5'd3; wdata = 32'h3333_3333;
      step();
      idle(); rs1 = 5'd3;
      settle();
      checks++; if (p1 !== 1'b1) begin errors++; $display("FAIL simul_pending got=%b exp=1", p1); end
      checks++; if (sberr !== 1'b0) begin errors++; $display("FAIL simul_err got=%b exp=0", sberr); end
      checks++; if (rd1 !== 32'h3333_3333) begin errors++; $display("FAIL simul_data got=%h exp=33333333", rd1); end
      we = 1'b1; wrd = 5'd3; wdata = 32'h3;
      step();
      idle(); rs1 = 5'd3;
      settle();
      checks++; if (p1 !== 1'b0) begin errors++; $display("FAIL simul_drain got=%b exp=0", p1); end
   endtask

   task automatic test_squash();
      idle(); iv = 1'b1; iwe = 1'b1; ird = 5'd9;
      step();
      idle(); we = 1'b1; wrd = 5'd9; wdata = 32'h1234_5678;
      step();
      idle(); iv = 1'b1; iwe = 1'b1; ird = 5'd9;
      step();
      idle(); sqv = 1'b1; sqrd = 5'd9; rs1 = 5'd9;
      settle();
      checks++; if (p1 !== 1'b1) begin errors++; $display("FAIL squash_pre got=%b exp=1", p1); end
      step();
      idle(); rs1 = 5'd9;
      settle();
      checks++; if (p1 !== 1'b0) begin errors++; $display("FAIL squash_pending got=%b exp=0", p1); end
      checks++; if (rd1 !== 32'h1234_5678) begin errors++; $display("FAIL squash_data got=%h exp=12345678", rd1); end
      // Two issues, then a squash and a retire on x9 together: two decrements.
      iv = 1'b1; iwe = 1'b1; ird = 5'd9;
      step();
      step();
      idle(); sqv = 1'b1; sqrd = 5'd9; we = 1'b1; wrd = 5'd9; wdata = 32'h9999_0000;
      step();
      idle(); rs1 = 5'd9;
      settle();
      checks++; if (p1 !== 1'b0) begin errors++; $display("FAIL dbl_dec_pending got=%b exp=0", p1); end
      checks++; if (sberr !== 1'b0) begin errors++; $display("FAIL dbl_dec_err got=%b exp=0", sberr); end
      checks++; if (rd1 !== 32'h9999_0000) begin errors++; $display("FAIL dbl_dec_data got=%h exp=99990000", rd1); end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         idle(); iv = 1'b1; iwe = 1'b1; ird = 5'd4;
         step();
      end
      idle(); rs1 = 5'd4;
      settle();
      checks++; if (sberr !== 1'b0) begin errors++; $display("FAIL sat_at_max_err got=%b exp=0", sberr); end
      iv = 1'b1; iwe = 1'b1; ird = 5'd4;
      step();
      idle(); rs1 = 5'd4;
      settle();
      checks++; if (sberr !== 1'b1) begin errors++; $display("FAIL sat_over_err got=%b exp=1", sberr); end
      // Held at 3: three retires drain it without underflow noise mattering.
      for (int i = 0; i < 3; i++) begin
         idle(); we = 1'b1; wrd = 5'd4; wdata = 32'h4;
         step();
      end
      idle(); rs1 = 5'd4;
      settle();
      checks++; if (p1 !== 1'b0) begin errors++; $display("FAIL sat_hold3 got=%b exp=0", p1); end
      do_reset();
      idle(); we = 1'b1; wrd = 5'd4; wdata = 32'h0000_A5A5;
      step();
      idle(); rs1 = 5'd4;
      settle();
      checks++; if (sberr !== 1'b1) begin errors++; $display("FAIL under_err got=%b exp=1", sberr); end
      checks++; if (p1 !== 1'b0) begin errors++; $display("FAIL under_pending got=%b exp=0", p1); end
      checks++; if (rd1 !== 32'h0000_A5A5) begin errors++; $display("FAIL under_data got=%h exp=0000a5a5", rd1); end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         idle();
         RST   = ($urandom_range(0, 59) == 0);
         we    = $urandom_range(0, 1) == 1;
         wrd   = 5'($urandom_range(0, 7));
         wdata = $urandom;
         rs1   = 5'($urandom_range(0, 7));
         rs2   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         iv    = $urandom_range(0, 1) == 1;
         iwe   = $urandom_range(0, 3) != 0;
         ird   = 5'($urandom_range(0, 7));
         sqv   = $urandom_range(0, 5) == 0;
         sqrd  = 5'($urandom_range(0, 7));
         settle();
         checks++; if (rd1 !== m_read(rs1)) begin errors++; $display("FAIL rnd_rd1 cyc=%0d rs=%0d got=%h exp=%h", c, rs1, rd1, m_read(rs1)); end
         checks++; if (rd2 !== m_read(rs2)) begin errors++; $display("FAIL rnd_rd2 cyc=%0d rs=%0d got=%h exp=%h", c, rs2, rd2, m_read(rs2)); end
         checks++; if (p1 !== (m_cnt[rs1] != 0)) begin errors++; $display("FAIL rnd_p1 cyc=%0d rs=%0d got=%b exp=%b", c, rs1, p1, m_cnt[rs1] != 0); end
         checks++; if (p2 !== (m_cnt[rs2] != 0)) begin errors++; $display("FAIL rnd_p2 cyc=%0d rs=%0d got=%b exp=%b", c, rs2, p2, m_cnt[rs2] != 0); end
         checks++; if (sberr !== m_err) begin errors++; $display("FAIL rnd_sberr cyc=%0d got=%b exp=%b", c, sberr, m_err); end
         step();
      end
   endtask

   initial begin
      for (int r = 0; r < 32; r++) begin
         m_reg[r] = '0;
         m_cnt[r] = 0;
      end
      m_err = 1'b0;
      idle();
      RST = 1'b1;
      step();
      step();
      test_reset();
      test_write_bypass();
      test_scoreboard();
      test_simultaneous();
      test_squash();
      test_saturation();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/reg_file_wb.md
# reg_file_wb

Integer register file for the RV32IM pipeline, acting as the receiving end of the WB stage's writeback interface (`WB_WRITE_ENABLE`, `WB_WRITE_DATA`, `WB_RD`). It serves the two ID-stage read ports, with same-cycle write-to-read bypass. It also keeps a per-register pending-write scoreboard, updated on issue from ID and on retire at WB, so the hazard unit can see outstanding producers.

## Interface
Parameters:
- `XLEN`, 32, register width
- `SB_BITS`, 2, width of each per-register pending counter (max 3 in flight)

Ports:
- `CLK`  in  1  clock, all state updates on rising edge
- `RST`  in  1  synchronous active-high reset (one clock; reset is synchronous and active-high)
- `WB_WRITE_ENABLE`  in  1  writeback strobe from WB stage
- `WB_WRITE_DATA`  in  XLEN  writeback data
- `WB_RD`  in  5  writeback destination
- `ID_RS1`, `ID_RS2`  in  5 each  read addresses
- `ID_READ_DATA1`, `ID_READ_DATA2`  out  XLEN each  read data (combinational)
- `ID_ISSUE_VALID`  in  1  instruction leaves ID this cycle
- `ID_ISSUE_WRITE_ENABLE`  in  1  issued instruction writes rd
- `ID_ISSUE_RD`  in  5  issued instruction's rd
- `SQUASH_VALID`  in  1  an issued writer was killed before WB
- `SQUASH_RD`  in  5  rd of the killed writer
- `ID_RS1_PENDING`, `ID_RS2_PENDING`  out  1 each  source has a nonzero pending count
- `SB_ERROR`  out  1  sticky scoreboard over/underflow flag

## Operation
- Storage: x1..x31 are flops. x0 reads as 0 always and ignores writes.
- Write: on an edge with `WB_WRITE_ENABLE`=1 and `WB_RD`≠0, reg[`WB_RD`] <= `WB_WRITE_DATA`.
- Read: `ID_READ_DATAn` = 0 if `ID_RSn`=0. Otherwise it is `WB_WRITE_DATA` if `WB_WRITE_ENABLE` && `WB_RD`==`ID_RSn`, else reg[`ID_RSn`] (write-first bypass).
- Scoreboard: one `SB_BITS` counter per register 1..31. Counter 0 does not exist and always reads as 0.
  - inc = `ID_ISSUE_VALID` && `ID_ISSUE_WRITE_ENABLE` && `ID_ISSUE_RD`≠0
  - dec sources:
    - `WB_WRITE_ENABLE` && `WB_RD`≠0, on `WB_RD`
    - `SQUASH_VALID` && `SQUASH_RD`≠0, on `SQUASH_RD`
  - Net update per register = incs − decs targeting it; up to two decs and one inc can hit the same register in one cycle.
  - Saturation:
    - A result above 2^SB_BITS−1 holds at max and sets `SB_ERROR`.
    - A result below 0 holds at 0 and sets `SB_ERROR`.
- `ID_RSn_PENDING` = counter[`ID_RSn`]≠0, evaluated on the current (pre-edge) counter value. There is no bypass of the same-cycle retire; the hazard unit covers that case through forwarding.
- `SB_ERROR` is sticky until `RST`.

## Timing
- Reset: on an edge with `RST`=1:
  - all registers are set to 0
  - all counters are set to 0
  - `SB_ERROR` is set to 0
  - writes, issues and squashes in that cycle are ignored
- Outputs after reset: reads return 0 and `PENDING` reads 0.
- Reset mid-operation discards all in-flight pending state. The pipeline must flush alongside.
- Write latency: data is visible via bypass in the same cycle, and from the array from the next cycle.
- Scoreboard latency:
  - An issue at edge N makes PENDING=1 from cycle N+1.
  - A retire at edge M drops PENDING from cycle M+1 if the count reaches 0.
- Simultaneous inc and dec on the same register leaves the count unchanged with no error.
- Same-reg double write is impossible (single write port). A squash and a WB retire on the same rd in one cycle count as two decrements.
- Reads are purely combinational from the address and WB inputs. There is no read handshake.

## Test plan
- Reset then read: `RST`=1 for 1 cycle, then `ID_RS1`=5, `ID_RS2`=0 -> both read 0x00000000; `PENDING`=0; `SB_ERROR`=0.
- Write/bypass:
  - Stimulus: WB writes x1=0xDEADBEEF while `ID_RS1`=1.
  - Same cycle: `ID_READ_DATA1`=0xDEADBEEF.
  - Next cycle, WB idle: still 0xDEADBEEF.
  - A write to x0=0xCAFEBABE followed by a read of x0 returns 0.
- Scoreboard lifecycle:
  - Cycle 0: issue rd=7. Cycle 1: issue rd=7 again. Cycle 2: `ID_RS2`=7.
  - Cycle 2: `ID_RS2_PENDING`=1.
  - WB write to x7 → still pending; second WB write to x7 → `PENDING`=0 the next cycle.
- Simultaneous events: counter[3]=1; same cycle, issue rd=3 and WB write rd=3 → counter stays 1, `PENDING`=1, `SB_ERROR`=0.
- Squash: issue rd=9, then `SQUASH_VALID` with rd=9 → `PENDING` for x9=0; register value of x9 unchanged from its prior value.
- Saturation/underflow:
  - Four issues to rd=4 with no retire → counter holds 3, `SB_ERROR`=1.
  - After `RST`, a WB write to x4 with a zero count → counter stays 0, `SB_ERROR`=1, and x4 is still written.
